branch_resolve_unit: RTL

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit_if.sv | 36 +++
 rtl/branch_resolve_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: branch results in, predictor updates and recovery requests out
interface branch_resolve_unit_if #(
  parameter int LANES = 2,
  parameter int AL_W  = 6,
  parameter int GH_W  = 10
);
  logic [LANES-1:0]      br_valid, br_mispred, br_taken, br_is_cond;
  logic [32*LANES-1:0]   br_addr, br_next;
  logic [GH_W*LANES-1:0] br_gh;
  logic [2*LANES-1:0]    br_pht;
  logic [AL_W*LANES-1:0] br_alptr;
  logic [AL_W-1:0]       al_head;
  logic                  in_ready;
  logic                  upd_valid, upd_ready;
  logic [31:0]           upd_addr, upd_next;
  logic                  upd_taken, upd_is_cond;
  logic [GH_W-1:0]       upd_gh;
  logic [1:0]            upd_pht;
  logic                  rec_req, rec_ack;
  logic [31:0]           rec_target;
  logic [AL_W-1:0]       rec_alptr;
  logic                  err_ovf;
  logic [31:0]           perf_br, perf_mis;
  modport master (
    output br_valid, br_mispred, br_taken, br_is_cond, br_addr, br_next, br_gh, br_pht,
           br_alptr, al_head, upd_ready, rec_ack,
    input  in_ready, upd_valid, upd_addr, upd_next, upd_taken, upd_is_cond, upd_gh, upd_pht,
           rec_req, rec_target, rec_alptr, err_ovf, perf_br, perf_mis
  );
  modport slave (
    input  br_valid, br_mispred, br_taken, br_is_cond, br_addr, br_next, br_gh, br_pht,
           br_alptr, al_head, upd_ready, rec_ack,
    output in_ready, upd_valid, upd_addr, upd_next, upd_taken, upd_is_cond, upd_gh, upd_pht,
           rec_req, rec_target, rec_alptr, err_ovf, perf_br, perf_mis
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: queues resolved branches for predictor update and raises recovery for the oldest mispredict; BRU_PERF_COUNTERS_EN enables perf counters
module branch_resolve_unit #(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int AL_W  = 6,
  parameter int GH_W  = 10
) (
  input logic clk,
  input logic rst,
  branch_resolve_unit_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  typedef struct packed {
    logic [31:0]     addr;
    logic [31:0]     next;
    logic            taken;
    logic            is_cond;
    logic [GH_W-1:0] gh;
    logic [1:0]      pht;
  } entry_t;
  typedef enum logic {IDLE, REQ} state_t;
  entry_t          mem [DEPTH];
  logic [PW-1:0]   wp, rp;
  logic [PW:0]     count, n_enq;
  logic [PW-1:0]   off [LANES];
  logic            enq_ok, deq, err;
  state_t          state, state_nx;
  logic [31:0]     tgt, tgt_nx, best_next;
  logic [AL_W-1:0] ptr, ptr_nx, best_ptr, best_age, age, held_age;
  logic            any_mis;
  assign bus.in_ready    = (DEPTH - int'(count)) >= LANES;
  assign bus.upd_valid   = count != '0;
  assign bus.upd_addr    = mem[rp].addr;
  assign bus.upd_next    = mem[rp].next;
  assign bus.upd_taken   = mem[rp].taken;
  assign bus.upd_is_cond = mem[rp].is_cond;
  assign bus.upd_gh      = mem[rp].gh;
  assign bus.upd_pht     = mem[rp].pht;
  assign bus.rec_req     = state == REQ;
  assign bus.rec_target  = tgt;
  assign bus.rec_alptr   = ptr;
  assign bus.err_ovf     = err;
  assign enq_ok          = bus.in_ready;
  assign deq             = bus.upd_valid && bus.upd_ready;
  assign held_age        = ptr - bus.al_head;
  // compact valid lanes into consecutive slots after the write pointer
  always_comb begin
    n_enq = '0;
    for (int l = 0; l < LANES; l++) begin
      off[l] = wp + n_enq[PW-1:0];
      n_enq  = n_enq + (PW+1)'(bus.br_valid[l]);
    end
  end
  // pick the oldest mispredicting lane relative to al_head; lowest lane wins ties
  always_comb begin
    any_mis   = 1'b0;
    best_age  = '0;
    best_ptr  = '0;
    best_next = '0;
    age       = '0;
    for (int l = 0; l < LANES; l++) begin
      age = bus.br_alptr[l*AL_W +: AL_W] - bus.al_head;
      if (bus.br_valid[l] && bus.br_mispred[l] && (!any_mis || age < best_age)) begin
        any_mis   = 1'b1;
        best_age  = age;
        best_ptr  = bus.br_alptr[l*AL_W +: AL_W];
        best_next = bus.br_next[l*32 +: 32];
      end
    end
  end
  // recovery FSM: capture when idle or acked, otherwise only a strictly older mispredict replaces
  always_comb begin
    state_nx = state == IDLE ? (any_mis ? REQ : IDLE) : (bus.rec_ack && !any_mis ? IDLE : REQ);
    tgt_nx   = tgt;
    ptr_nx   = ptr;
    if (any_mis && (state == IDLE || bus.rec_ack || best_age < held_age)) begin
      tgt_nx = best_next;
      ptr_nx = best_ptr;
    end
  end
  // recovery state and held redirect
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      tgt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      tgt   <= tgt_nx;
      ptr   <= ptr_nx;
    end
  // FIFO pointers, occupancy and sticky overflow; a whole cycle is dropped when there is no room
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (enq_ok) wp <= wp + n_enq[PW-1:0];
      if (deq) rp <= rp + 1'b1;
      count <= count + (enq_ok ? n_enq : '0) - (PW+1)'(deq);
      if (|bus.br_valid && !enq_ok) err <= 1'b1;
    end
  // FIFO storage needs no reset since occupancy gates visibility
  always_ff @(posedge clk)
    for (int l = 0; l < LANES; l++)
      if (enq_ok && bus.br_valid[l])
        mem[off[l]] <= '{addr: bus.br_addr[l*32 +: 32], next: bus.br_next[l*32 +: 32],
                         taken: bus.br_taken[l], is_cond: bus.br_is_cond[l],
                         gh: bus.br_gh[l*GH_W +: GH_W], pht: bus.br_pht[l*2 +: 2]};
`ifdef BRU_PERF_COUNTERS_EN
  logic [31:0] pbr, pmis;
  assign bus.perf_br  = pbr;
  assign bus.perf_mis = pmis;
  // count enqueued branches and all reported mispredicts
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pbr  <= '0;
      pmis <= '0;
    end else begin
      pbr  <= pbr + (enq_ok ? 32'(n_enq) : 32'd0);
      pmis <= pmis + 32'($countones(bus.br_valid & bus.br_mispred));
    end
`else
  assign bus.perf_br  = '0;
  assign bus.perf_mis = '0;
`endif
endmodule
